// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - valid/ready read port of the UART receive FIFO

interface uart_rx_fifo_if #(
  parameter int DW = 11
) ();
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - configurable UART receiver with error flags, error counters and FWFT FIFO

module uart_rx_fifo #(
  parameter int pMAX_DATA_BITS = 9,
  parameter int pFIFO_DEPTH    = 16,
  parameter int pCNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   bit_rate,
  input  logic [3:0]                    data_bits,
  input  logic [1:0]                    stop_bits,
  input  logic                          parity_bit,
  input  logic                          parity_enabled,
  input  logic                          parity_accept_errors,
  input  logic                          rxd,
  input  logic                          clear_status,
  uart_rx_fifo_if.master                rd,
  output logic [$clog2(pFIFO_DEPTH):0]  fifo_count,
  output logic                          overflow,
  output logic [pCNT_WIDTH-1:0]         parity_err_count,
  output logic [pCNT_WIDTH-1:0]         frame_err_count,
  output logic                          busy
);

  localparam int MW = pMAX_DATA_BITS;
  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam int WW = MW + 2;
  localparam logic [AW:0]           FULL_CNT = (AW + 1)'(pFIFO_DEPTH);
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE  = pCNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rxd_meta, rxd_s, rxd_prev;
  logic [15:0]     cnt_q, br_q;
  logic [3:0]      nbits_q, bit_idx_q, nbits_in;
  logic            two_stop_q, stop_idx_q, par_en_q, par_odd_q, accept_q;
  logic [MW-1:0]   data_q;
  logic            par_err_q, frame_err_q;
  logic            rxd_fall, sample, start_frame, frame_done, push_req, fe_final;
  logic [3:0]      shift;
  logic [WW-1:0]   word;
  logic [WW-1:0]   mem [pFIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            pop, push_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign rxd_fall = rxd_prev & ~rxd_s;
  assign sample   = (cnt_q == 16'd0);
  assign fe_final = frame_err_q | ~rxd_s;
  assign nbits_in = (data_bits < 4'd5) ? 4'd5 :
                    (data_bits > 4'(MW)) ? 4'(MW) : data_bits;
  // Data arrives LSB first into the top of data_q; realign for short frames.
  assign shift    = 4'(MW) - nbits_q;
  assign word     = {fe_final, par_err_q, data_q >> shift};

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    push_req    = 1'b0;
    case (state_q)
      S_IDLE:   if (rxd_fall) begin
                  state_d     = S_START;
                  start_frame = 1'b1;
                end
      S_START:  if (sample) state_d = rxd_s ? S_IDLE : S_DATA;
      S_DATA:   if (sample && bit_idx_q == nbits_q - 4'd1)
                  state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (sample) state_d = S_STOP;
      S_STOP:   if (sample && stop_idx_q == two_stop_q) begin
                  frame_done = 1'b1;
                  push_req   = !(par_err_q && !accept_q);
                  state_d    = rxd_s ? S_IDLE : S_BREAK;
                end
      S_BREAK:  if (rxd_s) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      br_q        <= '0;
      nbits_q     <= 4'd5;
      bit_idx_q   <= '0;
      two_stop_q  <= 1'b0;
      stop_idx_q  <= 1'b0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      accept_q    <= 1'b0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_frame) begin
        cnt_q       <= bit_rate >> 1;
        br_q        <= bit_rate;
        nbits_q     <= nbits_in;
        two_stop_q  <= (stop_bits >= 2'd2);
        par_en_q    <= parity_enabled;
        par_odd_q   <= parity_bit;
        accept_q    <= parity_accept_errors;
        bit_idx_q   <= '0;
        stop_idx_q  <= 1'b0;
        data_q      <= '0;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end else if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
        cnt_q <= sample ? br_q - 16'd1 : cnt_q - 16'd1;
        if (sample) begin
          case (state_q)
            S_DATA: begin
              data_q    <= {rxd_s, data_q[MW-1:1]};
              bit_idx_q <= bit_idx_q + 4'd1;
            end
            S_PARITY: par_err_q <= rxd_s ^ (^data_q) ^ par_odd_q;
            S_STOP: begin
              if (!rxd_s) frame_err_q <= 1'b1;
              stop_idx_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign rd.out_valid = (fifo_count != '0);
  assign rd.out_data  = rd.out_valid ? mem[rd_ptr] : '0;
  assign pop          = rd.out_valid & rd.out_ready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push_ok      = push_req & ((fifo_count != FULL_CNT) | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow         <= 1'b0;
      parity_err_count <= '0;
      frame_err_count  <= '0;
    end else if (clear_status) begin
      overflow         <= 1'b0;
      parity_err_count <= '0;
      frame_err_count  <= '0;
    end else begin
      if (push_req && !push_ok) overflow <= 1'b1;
      if (frame_done && par_err_q && parity_err_count != '1)
        parity_err_count <= parity_err_count + CNT_ONE;
      if (frame_done && fe_final && frame_err_count != '1)
        frame_err_count <= frame_err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a frame-level model

module tb_uart_rx_fifo;

  localparam int MW    = 9;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int DW    = MW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   bit_rate;
  logic [3:0]    data_bits;
  logic [1:0]    stop_bits;
  logic          parity_bit, parity_enabled, parity_accept_errors;
  logic          rxd, clear_status;
  logic [2:0]    fifo_count;
  logic          overflow, busy;
  logic [CW-1:0] parity_err_count, frame_err_count;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DW(DW)) u_if ();

  uart_rx_fifo #(
    .pMAX_DATA_BITS (MW),
    .pFIFO_DEPTH    (DEPTH),
    .pCNT_WIDTH     (CW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .bit_rate             (bit_rate),
    .data_bits            (data_bits),
    .stop_bits            (stop_bits),
    .parity_bit           (parity_bit),
    .parity_enabled       (parity_enabled),
    .parity_accept_errors (parity_accept_errors),
    .rxd                  (rxd),
    .clear_status         (clear_status),
    .rd                   (u_if),
    .fifo_count           (fifo_count),
    .overflow             (overflow),
    .parity_err_count     (parity_err_count),
    .frame_err_count      (frame_err_count),
    .busy                 (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_pe, exp_fe;
  bit exp_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_clear();
    exp_pe  = 0;
    exp_fe  = 0;
    exp_ovf = 1'b0;
  endfunction

  // Frame-level reference: what the word should look like and whether it lands.
  function automatic void model_frame(input int data, input int nb, input bit pen,
                                      input bit bad_par, input bit fe, input bit accept);
    bit pe;
    int d;
    pe = pen & bad_par;
    d  = data & ((1 << nb) - 1);
    if (pe) exp_pe++;
    if (fe) exp_fe++;
    if (pe && !accept) return;
    if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back((int'(fe) << 10) | (int'(pe) << 9) | d);
  endfunction

  task automatic send_frame(input int data, input int db, input int br, input bit pen,
                            input bit podd, input bit accept, input int nstop_cfg,
                            input bit bad_par, input int stop_low);
    int nb, ns;
    bit p;
    nb = (db < 5) ? 5 : ((db > MW) ? MW : db);
    ns = (nstop_cfg >= 2) ? 2 : 1;
    bit_rate             = 16'(br);
    data_bits            = 4'(db);
    stop_bits            = 2'(nstop_cfg);
    parity_bit           = podd;
    parity_enabled       = pen;
    parity_accept_errors = accept;
    rxd = 1'b0;
    cycles(br);
    bit_rate             = 16'($urandom_range(4, 60));
    data_bits            = 4'($urandom);
    stop_bits            = 2'($urandom);
    parity_bit           = 1'($urandom);
    parity_enabled       = 1'($urandom);
    parity_accept_errors = 1'($urandom);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      rxd = data[i];
      p   = p ^ data[i];
      cycles(br);
    end
    if (pen) begin
      rxd = p ^ podd ^ bad_par;
      cycles(br);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      cycles(br * stop_low);
      rxd = 1'b1;
    end else begin
      rxd = 1'b1;
      cycles(br * ns);
    end
    cycles(br * 2);
    model_frame(data, nb, pen, bad_par, stop_low > 0, accept);
  endtask

  task automatic drain();
    check_eq("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    check_eq("parity_err_count", 32'(parity_err_count), 32'(exp_pe));
    check_eq("frame_err_count", 32'(frame_err_count), 32'(exp_fe));
    while (exp_q.size() > 0) begin
      check_eq("out_valid", 32'(u_if.out_valid), 32'd1);
      check_eq("out_data", 32'(u_if.out_data), 32'(exp_q[0]));
      u_if.out_ready = 1'b1;
      cycles(1);
      u_if.out_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    check_eq("empty_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("empty_count", 32'(fifo_count), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    cycles(1);
    clear_status = 1'b0;
    cycles(1);
    model_clear();
    check_eq("clr_overflow", 32'(overflow), 32'd0);
    check_eq("clr_parity_cnt", 32'(parity_err_count), 32'd0);
    check_eq("clr_frame_cnt", 32'(frame_err_count), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb_frames, db, br, ns;
    bit pen, bad;
    reset = 1'b1;
    rxd = 1'b1;
    clear_status = 1'b0;
    u_if.out_ready = 1'b0;
    bit_rate = 16'd16;
    data_bits = 4'd8;
    stop_bits = 2'd0;
    parity_bit = 1'b0;
    parity_enabled = 1'b0;
    parity_accept_errors = 1'b0;
    model_clear();
    cycles(3);
    check_eq("rst_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("rst_data", 32'(u_if.out_data), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pe_cnt", 32'(parity_err_count), 32'd0);
    check_eq("rst_fe_cnt", 32'(frame_err_count), 32'd0);
    reset = 1'b0;
    cycles(4);

    // 8N1 0xA5 with push-to-valid latency observed at the end of the frame
    fork
      send_frame(32'hA5, 8, 16, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
      begin
        int t;
        bit prev;
        t = 0;
        while (!busy && t < 200) begin cycles(1); t++; end
        check_eq("lat_busy_rise", 32'(busy), 32'd1);
        t = 0;
        prev = u_if.out_valid;
        while (busy && t < 400) begin
          prev = u_if.out_valid;
          cycles(1);
          t++;
        end
        check_eq("lat_busy_fall", 32'(busy), 32'd0);
        check_eq("lat_valid_before", 32'(prev), 32'd0);
        check_eq("lat_valid_after", 32'(u_if.out_valid), 32'd1);
      end
    join
    drain();

    // 7E1 with a bad parity bit: dropped, then accepted
    send_frame(32'h41, 7, 16, 1'b1, 1'b0, 1'b0, 0, 1'b1, 0);
    drain();
    send_frame(32'h41, 7, 16, 1'b1, 1'b0, 1'b1, 0, 1'b1, 0);
    drain();

    // 9-bit frame with a long low stop, then a clean frame after the break
    send_frame(32'h1FF, 9, 16, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3);
    send_frame(32'h055, 9, 16, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    drain();
    pulse_clear();

    // overflow into a 4-deep FIFO
    for (int i = 1; i <= 6; i++)
      send_frame(i * 17, 8, 12, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    drain();
    pulse_clear();

    // short low glitch is rejected by the start-bit check
    bit_rate = 16'd16;
    rxd = 1'b0;
    cycles(3);
    check_eq("glitch_busy", 32'(busy), 32'd1);
    rxd = 1'b1;
    cycles(40);
    check_eq("glitch_idle", 32'(busy), 32'd0);
    drain();

    // reset in the middle of the data field
    bit_rate = 16'd16;
    data_bits = 4'd8;
    parity_enabled = 1'b0;
    rxd = 1'b0;
    cycles(16);
    rxd = 1'b1;
    cycles(16);
    rxd = 1'b0;
    cycles(8);
    check_eq("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    rxd = 1'b1;
    cycles(2);
    check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    cycles(4);
    send_frame(32'h3C, 8, 16, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    drain();

    // random frame batches
    for (int b = 0; b < 10; b++) begin
      nb_frames = $urandom_range(1, 5);
      for (int f = 0; f < nb_frames; f++) begin
        db  = $urandom_range(0, 15);
        br  = $urandom_range(6, 20);
        ns  = $urandom_range(0, 3);
        pen = 1'($urandom);
        bad = pen && ($urandom_range(0, 3) == 0);
        send_frame(int'($urandom & 32'h1FF), db, br, pen, 1'($urandom), 1'($urandom), ns, bad,
                   (!bad && $urandom_range(0, 4) == 0) ? ((ns >= 2) ? 3 : 2) : 0);
      end
      drain();
      pulse_clear();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
